aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
//
// PURPOSE
//  Iterative AES-128 encryption round controller. Owns the state register and
//  the round counter, and time-shares one combinational round datapath (the
//  sub_bytes instance plus shift-rows, mix-columns and add-round-key) across all
//  rounds, one round per clock.
//  Sits between the block-input stream and the ciphertext stream. Round keys
//  come from an external, precomputed key table indexed by round_idx.
//
// PARAMETERS
//  NUM_ROUNDS   10  rounds after the initial add-round-key (AES-128)
//  RIDX_W       4   width of round_idx; must hold NUM_ROUNDS
//
// PORTS
//  clk        in   1              single clock, rising edge
//  rst_n      in   1              asynchronous active-low reset
//  in_valid   in   1              in_block is valid
//  in_ready   out  1              controller can accept a block
//  in_block   in   byte_table     plaintext; [0][0] = first byte
//  round_idx  out  RIDX_W         index of the key currently required
//  round_key  in   byte_table     key for round_idx, same cycle (combinational lookup)
//  out_valid  out  1              out_block holds ciphertext
//  out_ready  in   1              downstream accepts out_block
//  out_block  out  byte_table     ciphertext, same byte order as in_block
//  busy       out  1              a block is in flight (ROUND or DONE)
//
// BEHAVIOUR
//  Reset values: in_ready=0 in the reset cycle, 1 from the first clock after
//   rst_n releases. out_valid=0, out_block=0, busy=0, round_idx=0, state reg=0.
//   Internal FSM=IDLE and round counter=0.
//  Reset mid-operation: the in-flight block is discarded and no output is
//   produced.
//  FSM: IDLE -> ROUND -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1, round_idx=0.
//   - On in_valid: state <= in_block ^ round_key (key 0); rnd <= 1; go to ROUND.
//  ROUND:
//   - in_ready=0, round_idx=rnd.
//   - Each cycle: state <= aes_round(state, round_key, last=(rnd==NUM_ROUNDS)).
//   - The last round skips mix-columns.
//   - rnd increments. After rnd==NUM_ROUNDS, go to DONE.
//  DONE:
//   - out_valid=1, out_block=state. Held stable until out_ready.
//   - On out_valid&&out_ready: go to IDLE.
//   - Same-cycle in_valid is NOT accepted (in_ready=0 in DONE).
//  Latency: handshake at cycle 0 -> out_valid at cycle NUM_ROUNDS+1 (11).
//  Throughput: one block per NUM_ROUNDS+2 cycles with out_ready held high.
//  round_idx is registered-state-derived only (no combinational path from
//   in_valid). round_key is sampled in the same cycle round_idx is presented.
//  in_block is sampled only on the accept edge; later changes are ignored.
//  The round counter never exceeds NUM_ROUNDS. It is cleared on the DONE->IDLE
//   transition.
//
// CONFIGURATION
//  AES_ROUND_CTRL_PERF_EN defined:
//   - Adds output blk_count, 32 bits: number of completed output handshakes.
//   - Reset 0; wraps 0xFFFFFFFF -> 0.
//  AES_ROUND_CTRL_PERF_EN undefined:
//   - No blk_count port or logic; behaviour otherwise identical.
//
// STRUCTURE
//  aes_model_pack holds:
//   - byte_table, COLUMN_COUNT, COLUMN_SIZE_IN_BYTES, SUB_BYTES_TABLE.
//   - New: shift_rows() and mix_columns() functions.
//   - New: round_ctrl_state_t enum {IDLE, ROUND, DONE}.
//   - New: AES128_ROUNDS=10.
//  Sub-module aes_round (combinational): sub_bytes -> shift_rows ->
//   (mix_columns unless last) -> xor round_key. Instantiated once; the
//   controller holds only the FSM, counter and registers.
//
// TESTING
//  1. FIPS-197 App.B:
//     pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c
//     -> out 3925841d02dc09fbdc118597196a0b32, out_valid exactly 11 cycles
//     after accept.
//  2. Backpressure: out_ready=0 for 20 cycles after out_valid -> out_block
//     stable, in_ready=0, busy=1. Release -> one handshake, then IDLE.
//  3. Back-to-back: 3 blocks (App.B pt, all-zero pt, all-FF pt) with in_valid
//     held high and out_ready=1 -> 3 outputs matching the model, 12 cycles
//     apart, in order.
//  4. round_idx sequence per block: 0,1,2,...,10, then held 10 in DONE; never
//     exceeds 10.
//  5. Reset in ROUND at rnd=5 -> all outputs at reset values immediately;
//     after release, a new App.B block yields the correct ciphertext.
//  6. PERF_EN build: after 3 completed blocks, blk_count=3. Force 0xFFFFFFFF,
//     complete 1 block -> blk_count=0.

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES-128 types, S-box and round helper functions for aes_round_ctrl.
// Optional AES_ROUND_CTRL_PERF_EN adds a completed-block counter to the bus.
package aes_model_pack;

    localparam int COLUMN_COUNT         = 4;
    localparam int COLUMN_SIZE_IN_BYTES = 4;
    localparam int AES128_ROUNDS        = 10;

    // [col][row]; as a 128-bit vector the first byte ([0][0]) is the MSB
    typedef logic [0:COLUMN_COUNT-1][0:COLUMN_SIZE_IN_BYTES-1][7:0] byte_table;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } round_ctrl_state_t;

    localparam logic [0:255][7:0] SUB_BYTES_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_table sub_bytes(input byte_table s);
        byte_table o;
        for (int c = 0; c < COLUMN_COUNT; c++)
            for (int r = 0; r < COLUMN_SIZE_IN_BYTES; r++)
                o[c][r] = SUB_BYTES_TABLE[s[c][r]];
        return o;
    endfunction

    // row r rotates left by r columns
    function automatic byte_table shift_rows(input byte_table s);
        byte_table o;
        for (int c = 0; c < COLUMN_COUNT; c++)
            for (int r = 0; r < COLUMN_SIZE_IN_BYTES; r++)
                o[c][r] = s[2'(c + r)][r];
        return o;
    endfunction

    function automatic byte_table mix_columns(input byte_table s);
        byte_table o;
        for (int c = 0; c < COLUMN_COUNT; c++) begin
            o[c][0] = xtime(s[c][0]) ^ xtime(s[c][1]) ^ s[c][1]
                    ^ s[c][2] ^ s[c][3];
            o[c][1] = s[c][0] ^ xtime(s[c][1]) ^ xtime(s[c][2])
                    ^ s[c][2] ^ s[c][3];
            o[c][2] = s[c][0] ^ s[c][1] ^ xtime(s[c][2])
                    ^ xtime(s[c][3]) ^ s[c][3];
            o[c][3] = xtime(s[c][0]) ^ s[c][0] ^ s[c][1]
                    ^ s[c][2] ^ xtime(s[c][3]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-in / key-lookup / ciphertext-out bundle of the AES round controller.
// AES_ROUND_CTRL_PERF_EN adds blk_count.
interface aes_round_ctrl_if #(parameter int RIDX_W = 4);
    import aes_model_pack::*;

    logic              in_valid;
    logic              in_ready;
    byte_table         in_block;
    logic [RIDX_W-1:0] round_idx;
    byte_table         round_key;
    logic              out_valid;
    logic              out_ready;
    byte_table         out_block;
    logic              busy;
`ifdef AES_ROUND_CTRL_PERF_EN
    logic [31:0]       blk_count;
`endif

    modport master (
        output in_valid, in_block, round_key, out_ready,
        input  in_ready, round_idx, out_valid, out_block, busy
`ifdef AES_ROUND_CTRL_PERF_EN
        , input blk_count
`endif
    );

    modport slave (
        input  in_valid, in_block, round_key, out_ready,
        output in_ready, round_idx, out_valid, out_block, busy
`ifdef AES_ROUND_CTRL_PERF_EN
        , output blk_count
`endif
    );

endinterface

// File: rtl/aes_round_ctrl_round.sv
// One combinational AES encryption round, shared across all rounds.
// Last round bypasses mix-columns.
module aes_round
    import aes_model_pack::*;
(
    input  byte_table state,
    input  byte_table round_key,
    input  logic      last,
    output byte_table next
);

    byte_table sb;
    byte_table sr;

    always_comb begin
        sb   = sub_bytes(state);
        sr   = shift_rows(sb);
        next = (last ? sr : mix_columns(sr)) ^ round_key;
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round controller: FSM, round counter and state register.
// AES_ROUND_CTRL_PERF_EN adds a 32-bit completed-handshake counter.
module aes_round_ctrl
    import aes_model_pack::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int RIDX_W     = 4
) (
    input logic             clk,
    input logic             rst_n,
    aes_round_ctrl_if.slave bus
);

    round_ctrl_state_t fsm;
    logic [RIDX_W-1:0] rnd;
    logic              live;
    byte_table         state;
    byte_table         round_out;
    logic              accept;
    logic              retire;
    logic              last;

    // live keeps in_ready low until the first clock after reset release
    assign bus.in_ready  = live && (fsm == IDLE);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (fsm == DONE);
    assign retire        = bus.out_valid && bus.out_ready;
    assign bus.out_block = bus.out_valid ? state : '0;
    assign bus.busy      = (fsm != IDLE);
    assign bus.round_idx = rnd;
    assign last          = (rnd == RIDX_W'(NUM_ROUNDS));

    aes_round u_round (
        .state     (state),
        .round_key (bus.round_key),
        .last      (last),
        .next      (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live  <= 1'b0;
            fsm   <= IDLE;
            rnd   <= '0;
            state <= '0;
        end else begin
            live <= 1'b1;
            unique case (1'b1)
                fsm == IDLE: begin
                    if (accept) begin
                        state <= bus.in_block ^ bus.round_key;
                        rnd   <= RIDX_W'(1);
                        fsm   <= ROUND;
                    end
                end
                fsm == ROUND: begin
                    state <= round_out;
                    if (last) fsm <= DONE;
                    else      rnd <= rnd + RIDX_W'(1);
                end
                fsm == DONE: begin
                    if (retire) begin
                        rnd <= '0;
                        fsm <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

`ifdef AES_ROUND_CTRL_PERF_EN
    logic [31:0] blk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      blk_cnt <= '0;
        else if (retire) blk_cnt <= blk_cnt + 32'd1;
    end

    assign bus.blk_count = blk_cnt;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl against an arithmetic AES-128 model.
// Builds with or without AES_ROUND_CTRL_PERF_EN.
module tb_aes_round_ctrl;
    import aes_model_pack::*;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_round_ctrl_if #(.RIDX_W(4)) bus();

    aes_round_ctrl #(.NUM_ROUNDS(10), .RIDX_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---- reference model: S-box from GF(2^8) inverse + affine map
    logic [7:0]   sb [256];
    logic [127:0] ktab [11];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                  ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]}
                  ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++)
            ktab[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        v = pt ^ ktab[0];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[v[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = s[4*((c + r) % 4) + r];
            for (int c = 0; c < 4; c++) begin
                if (rd < 10) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3)
                             ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2)
                             ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1]
                             ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1]
                             ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
            v = v ^ ktab[rd];
        end
        return v;
    endfunction

    // external key table: combinational lookup by round_idx
    always_comb begin
        bus.round_key = '0;
        if (bus.round_idx <= 4'd10) bus.round_key = ktab[bus.round_idx];
    end

    // ---- scoreboard / monitor
    typedef struct {
        logic [127:0] blk;
        int           cyc;
    } exp_t;

    exp_t         sbq [$];
    int           out_cycs [$];
    int           cyc = 0;
    int           acc = 0;
    bit           inflight = 0;
    bit           ov_seen = 0;
    logic [127:0] last_out = '0;
    logic [31:0]  perf_exp = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            inflight = 0;
            ov_seen  = 0;
            perf_exp = '0;
        end else begin
            if (bus.in_ready)
                chk("idx_idle", 128'(bus.round_idx), 128'(0));
            if (bus.in_valid && bus.in_ready) begin
                sbq.push_back('{model_enc(bus.in_block), cyc});
                inflight = 1;
                acc = cyc;
            end else if (inflight && !bus.out_valid) begin
                chk("idx_seq", 128'(bus.round_idx), 128'(cyc - acc));
            end
            if (bus.out_valid) begin
                chk("idx_done", 128'(bus.round_idx), 128'(10));
                if (!ov_seen && sbq.size() > 0)
                    chk("latency", 128'(cyc - sbq[0].cyc), 128'(11));
                ov_seen = 1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", 128'(1), 128'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("out_block", bus.out_block, e.blk);
                end
`ifdef AES_ROUND_CTRL_PERF_EN
                chk("blk_count", 128'(bus.blk_count), 128'(perf_exp));
                perf_exp = perf_exp + 32'd1;
`endif
                last_out = bus.out_block;
                out_cycs.push_back(cyc);
                inflight = 0;
                ov_seen  = 0;
            end
        end
    end

    // ---- driver tasks (called at posedge+1)
    task automatic send(input logic [127:0] pt);
        int n;
        bus.in_block = pt;
        bus.in_valid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (n == 50) chk("send_timeout", 128'(1), 128'(0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_block = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input int limit, input bit bp);
        int n;
        for (n = 0; n < limit; n++) begin
            if (bp) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) break;
            @(posedge clk);
            #1;
        end
        if (n == limit) chk("done_timeout", 128'(1), 128'(0));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(0));
        chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        chk({tag, "_busy"}, 128'(bus.busy), 128'(0));
        chk({tag, "_round_idx"}, 128'(bus.round_idx), 128'(0));
        chk({tag, "_out_block"}, bus.out_block, 128'(0));
    endtask

    initial begin
        logic [127:0] hold;
        logic [127:0] b2b [3];
        int n;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.out_ready = 1'b1;
        build_sbox();
        set_key(KEY_B);

        // reset values
        #2;
        chk_reset_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_low", 128'(bus.in_ready), 128'(0));
        @(posedge clk);
        #1;
        chk("rel_ready_high", 128'(bus.in_ready), 128'(1));

        // App.B vector
        send(PT_B);
        wait_done(40, 1'b0);
        chk("appB_ct", last_out, CT_B);

        // backpressure
        bus.out_ready = 1'b0;
        send(PT_B);
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        if (n == 30) chk("bp_timeout", 128'(1), 128'(0));
        hold = bus.out_block;
        chk("bp_ct", hold, CT_B);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_stable", bus.out_block, hold);
            chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
            chk("bp_busy", 128'(bus.busy), 128'(1));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_idle_busy", 128'(bus.busy), 128'(0));
        chk("bp_idle_ready", 128'(bus.in_ready), 128'(1));
        chk("bp_idle_valid", 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        #1;

        // back-to-back with in_valid held high
        b2b[0] = PT_B;
        b2b[1] = '0;
        b2b[2] = '1;
        out_cycs.delete();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_block = b2b[k];
            for (n = 0; n < 50; n++) begin
                @(negedge clk);
                if (bus.in_ready) break;
            end
            if (n == 50) chk("b2b_timeout", 128'(1), 128'(0));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (out_cycs.size() >= 3) break;
        end
        chk("b2b_count", 128'(out_cycs.size()), 128'(3));
        if (out_cycs.size() >= 3) begin
            chk("b2b_gap1", 128'(out_cycs[1] - out_cycs[0]), 128'(12));
            chk("b2b_gap2", 128'(out_cycs[2] - out_cycs[1]), 128'(12));
        end
        @(posedge clk);
        #1;

        // randomized keys, plaintexts and output stalls
        for (int k = 0; k < 8; k++) begin
            set_key({$urandom, $urandom, $urandom, $urandom});
            send({$urandom, $urandom, $urandom, $urandom});
            wait_done(200, 1'b1);
        end

        // reset in ROUND at rnd=5
        set_key(KEY_B);
        send(PT_B);
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.round_idx == 4'd5) break;
        end
        if (n == 30) chk("rnd5_timeout", 128'(1), 128'(0));
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(PT_B);
        wait_done(40, 1'b0);
        chk("post_rst_ct", last_out, CT_B);

`ifdef AES_ROUND_CTRL_PERF_EN
        send(PT_B);
        wait_done(40, 1'b0);
        send('0);
        wait_done(40, 1'b0);
        chk("perf_three", 128'(bus.blk_count), 128'(3));
        force dut.blk_cnt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.blk_cnt;
        perf_exp = 32'hFFFF_FFFF;
        send(PT_B);
        wait_done(40, 1'b0);
        chk("perf_wrap", 128'(bus.blk_count), 128'(0));
`endif

        chk("sb_empty", 128'(sbq.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
